// File: rtl/voice_allocator.sv
// voice_allocator: note-to-voice scheduler with free-voice assignment and oldest-voice stealing.
// Define RETRIGGER_GAP_EN to insert a one-cycle key-off gap on retrigger and steal.
module voice_allocator #(
   parameter int NUM_VOICES = 8,
   parameter int NOTE_W     = 7,
   parameter int AGE_W      = 8
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         ev_valid,
   output logic                         ev_ready,
   input  logic                         ev_note_on,
   input  logic [NOTE_W-1:0]            ev_note,
   input  logic                         panic,
   output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
   output logic [NUM_VOICES-1:0]        voice_key,
   output logic                         steal,
   output logic [4:0]                   active_count
);
   localparam int IW = $clog2(NUM_VOICES);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_APPLY = 2'd2;
`ifdef RETRIGGER_GAP_EN
   localparam logic [1:0] S_GAP   = 2'd3;
`endif
   logic [1:0]                          state_q, state_d;
   logic [IW-1:0]                       idx_q, idx_d;
   logic                                on_q, on_d;
   logic [NOTE_W-1:0]                   note_q, note_d;
   logic                                match_v_q, match_v_d, free_v_q, free_v_d, old_v_q, old_v_d;
   logic [IW-1:0]                       match_q, match_d, free_q, free_d, old_q, old_d;
   logic [AGE_W-1:0]                    old_age_q, old_age_d;
   logic [NUM_VOICES-1:0][NOTE_W-1:0]   notes_q, notes_d;
   logic [NUM_VOICES-1:0][AGE_W-1:0]    ages_q, ages_d;
   logic [NUM_VOICES-1:0]               key_q, key_d;
   logic                                steal_q, steal_d;
   logic [4:0]                          cnt_q, cnt_d;
   logic [IW-1:0]                       tgt;

   assign ev_ready     = (state_q == S_IDLE) && !panic;
   assign voice_note   = notes_q;
   assign voice_key    = key_q;
   assign steal        = steal_q;
   assign active_count = cnt_q;
   // Trackers stay frozen after the scan, so the target is stable through APPLY and GAP.
   assign tgt = match_v_q ? match_q : free_v_q ? free_q : old_q;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      on_d      = on_q;
      note_d    = note_q;
      match_v_d = match_v_q;
      free_v_d  = free_v_q;
      old_v_d   = old_v_q;
      match_d   = match_q;
      free_d    = free_q;
      old_d     = old_q;
      old_age_d = old_age_q;
      notes_d   = notes_q;
      ages_d    = ages_q;
      key_d     = key_q;
      steal_d   = 1'b0;
      if (panic) begin
         state_d = S_IDLE;
         key_d   = '0;
         ages_d  = '0;
      end else if (state_q == S_IDLE) begin
         if (ev_valid) begin
            state_d   = S_SCAN;
            idx_d     = '0;
            on_d      = ev_note_on;
            note_d    = ev_note;
            match_v_d = 1'b0;
            free_v_d  = 1'b0;
            old_v_d   = 1'b0;
            old_age_d = '0;
         end
      end else if (state_q == S_SCAN) begin
         if (key_q[idx_q] && notes_q[idx_q] == note_q && !match_v_q) begin
            match_v_d = 1'b1;
            match_d   = idx_q;
         end
         if (!key_q[idx_q] && !free_v_q) begin
            free_v_d = 1'b1;
            free_d   = idx_q;
         end
         // Strict compare keeps the lowest index on equal ages.
         if (key_q[idx_q] && (!old_v_q || ages_q[idx_q] > old_age_q)) begin
            old_v_d   = 1'b1;
            old_d     = idx_q;
            old_age_d = ages_q[idx_q];
         end
         idx_d   = idx_q + 1'b1;
         state_d = (idx_q == IW'(NUM_VOICES - 1)) ? S_APPLY : S_SCAN;
      end else if (state_q == S_APPLY) begin
         state_d = S_IDLE;
         if (on_q) begin
            for (int i = 0; i < NUM_VOICES; i++)
               if (key_q[i] && ages_q[i] != '1) ages_d[i] = ages_q[i] + 1'b1;
            ages_d[tgt]  = '0;
            notes_d[tgt] = note_q;
            key_d[tgt]   = 1'b1;
            steal_d      = !match_v_q && !free_v_q;
`ifdef RETRIGGER_GAP_EN
            if (match_v_q || !free_v_q) begin
               key_d[tgt] = 1'b0;
               state_d    = S_GAP;
            end
`endif
         end else if (match_v_q) begin
            key_d[match_q] = 1'b0;
         end
      end
`ifdef RETRIGGER_GAP_EN
      else if (state_q == S_GAP) begin
         key_d[tgt] = 1'b1;
         state_d    = S_IDLE;
      end
`endif
   end

   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < NUM_VOICES; i++) cnt_d = cnt_d + 5'(key_d[i]);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         on_q      <= 1'b0;
         note_q    <= '0;
         match_v_q <= 1'b0;
         free_v_q  <= 1'b0;
         old_v_q   <= 1'b0;
         match_q   <= '0;
         free_q    <= '0;
         old_q     <= '0;
         old_age_q <= '0;
         notes_q   <= '0;
         ages_q    <= '0;
         key_q     <= '0;
         steal_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         on_q      <= on_d;
         note_q    <= note_d;
         match_v_q <= match_v_d;
         free_v_q  <= free_v_d;
         old_v_q   <= old_v_d;
         match_q   <= match_d;
         free_q    <= free_d;
         old_q     <= old_d;
         old_age_q <= old_age_d;
         notes_q   <= notes_d;
         ages_q    <= ages_d;
         key_q     <= key_d;
         steal_q   <= steal_d;
         cnt_q     <= cnt_d;
      end
   end
endmodule
